// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, START/BUSY/DONE handshake.
// Modes: logical right, arithmetic right, logical left, rotate right.
module seq_shifter #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [1:0]   MODE,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] OUT,
  output logic         CARRY,
  output logic         BUSY,
  output logic         DONE
);

  localparam int LG = $clog2(N);
  localparam int CW = LG + 1;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_ASR = 2'b01;
  localparam logic [1:0] M_LSL = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_eff;
  logic            sat;
  logic            accept;

  // N is a power of two, so B >= N exactly when any bit at or above LG is set.
  assign sat = |B[N-1:LG];

  always_comb begin
    cnt_eff = {1'b0, B[LG-1:0]};
    if (MODE != M_ROR && sat) begin
      cnt_eff = CW'(N);
    end
  end

  assign accept = START && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      mode_q <= M_LSR;
      cnt_q  <= '0;
      OUT    <= '0;
      CARRY  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else if (accept) begin
      mode_q <= MODE;
      cnt_q  <= cnt_eff;
      OUT    <= A;
      CARRY  <= 1'b0;
      if (cnt_eff == '0) begin
        state <= S_DONE;
        BUSY  <= 1'b0;
        DONE  <= 1'b1;
      end else begin
        state <= S_SHIFT;
        BUSY  <= 1'b1;
        DONE  <= 1'b0;
      end
    end else begin
      case (state)
        S_SHIFT: begin
          case (mode_q)
            M_LSR: begin
              OUT   <= {1'b0, OUT[N-1:1]};
              CARRY <= OUT[0];
            end
            M_ASR: begin
              OUT   <= {OUT[N-1], OUT[N-1:1]};
              CARRY <= OUT[0];
            end
            M_LSL: begin
              OUT   <= {OUT[N-2:0], 1'b0};
              CARRY <= OUT[N-1];
            end
            M_ROR: begin
              OUT   <= {OUT[0], OUT[N-1:1]};
              CARRY <= OUT[0];
            end
            default: begin
              OUT   <= OUT;
              CARRY <= CARRY;
            end
          endcase
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (N=8) with a shift reference model.
module tb_seq_shifter;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   MODE = 2'b00;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [N-1:0] OUT;
  logic         CARRY;
  logic         BUSY;
  logic         DONE;

  int vectors = 0;
  int miscompares = 0;

  seq_shifter #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .A(A), .B(B),
    .OUT(OUT), .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference: whole-operand shift by the effective count, not bit stepping.
  function automatic void model(input logic [1:0] m, input logic [7:0] a,
                                input logic [7:0] b, output logic [7:0] o,
                                output logic c, output int cnt);
    logic [15:0] d;
    if (m == 2'b11) cnt = int'(b) % N;
    else            cnt = (int'(b) > N) ? N : int'(b);
    d = {a, a};
    o = '0;
    c = 1'b0;
    case (m)
      2'b00: o = a >> cnt;
      2'b01: o = 8'($signed(a) >>> cnt);
      2'b10: o = a << cnt;
      default: o = d[cnt +: 8];
    endcase
    if (cnt > 0) begin
      if (m == 2'b10) c = a[N - cnt];
      else            c = a[cnt - 1];
    end
  endfunction

  // Launch one operation; returns edges from acceptance to DONE (-1 on timeout).
  task automatic launch_op(input logic [1:0] m, input logic [7:0] a,
                           input logic [7:0] b, output int lat, output bit busy_ok);
    bit done_seen;
    @(negedge CLK);
    START = 1'b1; MODE = m; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0;
    A = 8'($urandom); B = 8'($urandom); MODE = 2'($urandom);
    lat = 0; busy_ok = 1'b1; done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (DONE) begin
        done_seen = 1'b1;
        if (BUSY) busy_ok = 1'b0;
      end else begin
        if (!BUSY) busy_ok = 1'b0;
        @(posedge CLK); #1;
        lat++;
      end
    end
    if (!done_seen) lat = -1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({OUT, CARRY, BUSY, DONE} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%b carry=%b busy=%b done=%b, want all zero",
               OUT, CARRY, BUSY, DONE);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic [1:0] m,
                               input logic [7:0] a, input logic [7:0] b);
    int lat, exp_cnt;
    bit busy_ok;
    logic [7:0] exp_o;
    logic exp_c;
    model(m, a, b, exp_o, exp_c, exp_cnt);
    launch_op(m, a, b, lat, busy_ok);
    vectors++;
    if (lat !== exp_cnt || OUT !== exp_o || CARRY !== exp_c || !busy_ok) begin
      miscompares++;
      $display("FAIL %s: got lat=%0d out=%b carry=%b busy_ok=%0d, want lat=%0d out=%b carry=%b busy_ok=1",
               name, lat, OUT, CARRY, busy_ok, exp_cnt, exp_o, exp_c);
    end
    @(posedge CLK); #1;
    vectors++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || OUT !== exp_o || CARRY !== exp_c) begin
      miscompares++;
      $display("FAIL %s_hold: got done=%b busy=%b out=%b carry=%b, want done=0 busy=0 out=%b carry=%b",
               name, DONE, BUSY, OUT, CARRY, exp_o, exp_c);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] m;
      logic [7:0] a, b;
      m = 2'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 9));
      test_directed("random", m, a, b);
    end
  endtask

  task automatic test_back_to_back();
    int lat, exp_cnt;
    logic [7:0] exp_o;
    logic exp_c;
    @(negedge CLK);
    START = 1'b1; MODE = 2'b00; A = 8'b00101011; B = 8'd3;
    @(posedge CLK); #1;
    A = 8'hF0; B = 8'd2; MODE = 2'b10;
    lat = 0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    vectors++;
    if (lat !== 3 || OUT !== 8'b00000101 || CARRY !== 1'b0) begin
      miscompares++;
      $display("FAIL start_during_shift: got lat=%0d out=%b carry=%b, want lat=3 out=00000101 carry=0",
               lat, OUT, CARRY);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    vectors++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_accept: got busy=%b done=%b, want busy=1 done=0", BUSY, DONE);
    end
    model(2'b10, 8'hF0, 8'd2, exp_o, exp_c, exp_cnt);
    lat = 0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    vectors++;
    if (lat !== exp_cnt || OUT !== exp_o || CARRY !== exp_c) begin
      miscompares++;
      $display("FAIL back_to_back_result: got lat=%0d out=%b carry=%b, want lat=%0d out=%b carry=%b",
               lat, OUT, CARRY, exp_cnt, exp_o, exp_c);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_op();
    @(negedge CLK);
    START = 1'b1; MODE = 2'b00; A = 8'b00101011; B = 8'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #3;
    vectors++;
    if (BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_busy: got busy=%b, want 1", BUSY);
    end
    RST = 1'b1;
    #1;
    vectors++;
    if ({OUT, CARRY, BUSY, DONE} !== 11'b0) begin
      miscompares++;
      $display("FAIL async_reset: got out=%b carry=%b busy=%b done=%b, want all zero",
               OUT, CARRY, BUSY, DONE);
    end
    @(negedge CLK); RST = 1'b0;
    test_directed("after_reset_lsr", 2'b00, 8'b00101011, 8'd3);
  endtask

  initial begin
    test_reset();
    test_directed("lsr_b3", 2'b00, 8'b00101011, 8'd3);
    test_directed("asr_sat", 2'b01, 8'b10001011, 8'd37);
    test_directed("lsr_sat", 2'b00, 8'b10001011, 8'd37);
    test_directed("ror_b5", 2'b11, 8'b01000101, 8'd5);
    test_directed("ror_b37", 2'b11, 8'b01000101, 8'd37);
    test_directed("lsl_b1", 2'b10, 8'b00001011, 8'd1);
    test_directed("lsl_b0", 2'b10, 8'b00001011, 8'd0);
    test_directed("asr_b8", 2'b01, 8'b01111111, 8'd8);
    test_directed("lsl_sat", 2'b10, 8'b10000001, 8'd200);
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the combinational right shifter.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- Shifts one bit position per clock and reports the last bit shifted out.
- Sits beside the ALU datapath and uses a START/BUSY/DONE handshake, so wide operands do not need a full barrel network.

Parameters:
- N, 8, operand/result width in bits; must be a power of two and at least 2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  request; accepted only in IDLE or DONE.
- MODE  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- A  input  N  operand to shift.
- B  input  N  shift amount, unsigned.
- OUT  output  N  result register.
- CARRY  output  1  last bit shifted out (or wrapped, for rotate).
- BUSY  output  1  high while in SHIFT.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - State goes to IDLE; OUT=0, CARRY=0, BUSY=0, DONE=0.
  - Any operation in progress is discarded.
- States: IDLE, SHIFT, DONE.
- Acceptance:
  - START is sampled at edge k while the state is IDLE or DONE.
  - A, MODE and the effective count CNT are latched at that edge. OUT is loaded with A and CARRY is cleared.
  - A, B and MODE are ignored after the acceptance edge; changing them during SHIFT has no effect.
- Effective count:
  - Modes 00/01/10: CNT = min(B, N).
  - Mode 11: CNT = B mod N.
  - Count register is $clog2(N)+1 bits wide.
- Transitions at edge k:
  - CNT=0: go directly to DONE; OUT=A, CARRY=0.
  - CNT>0: go to SHIFT.
- SHIFT state, each edge k+1 .. k+CNT performs one 1-bit step on OUT:
  - 00: zero fill at MSB; CARRY <= OUT[0].
  - 01: MSB replicated; CARRY <= OUT[0].
  - 10: zero fill at LSB; CARRY <= OUT[N-1].
  - 11: OUT[0] moves to MSB; CARRY <= OUT[0].
  - Count decrements each step. The edge performing the final step (count=1) moves to DONE.
- Latency: DONE is high for exactly one cycle, starting at edge k+CNT.
  - OUT and CARRY are final when DONE rises.
  - They hold until the next accepted START or reset.
- DONE state: returns to IDLE at the next edge unless START is high. If START is high, the new request is accepted back-to-back with no idle cycle.
- BUSY=1 exactly in SHIFT. START during SHIFT is ignored (not queued).
- Saturation results (B >= N):
  - Logical modes: OUT=0.
  - Arithmetic right: OUT = all copies of the sign bit.
  - CARRY = bit shifted out on the Nth step.
- Simultaneous RST and START: RST wins.

Test Plan (N=8):
1. Logical right:
   - Stimulus: MODE=00, A=00101011, B=3, START accepted at edge k.
   - Response: BUSY during k+1..k+3; DONE pulse at k+3; OUT=00000101, CARRY=0.
2. Arithmetic right, saturated:
   - Stimulus: MODE=01, A=10001011, B=00100101 (37).
   - Response: CNT saturates to 8; DONE at k+8; OUT=11111111, CARRY=1.
   - Repeat with MODE=00: OUT=00000000, CARRY=1.
3. Rotate right:
   - Stimulus: MODE=11, A=01000101, B=5.
   - Response: DONE at k+5; OUT=00101010, CARRY=0.
   - Repeat with B=37: identical OUT, CARRY and latency (37 mod 8 = 5).
4. Logical left and zero count:
   - Stimulus: MODE=10, A=00001011, B=1.
   - Response: DONE at k+1; OUT=00010110, CARRY=0.
   - Then B=0: DONE at edge k itself, BUSY never high, OUT=00001011, CARRY=0.
5. Handshake:
   - Hold START high during SHIFT with a different A: ignored, first result unchanged.
   - START asserted in the DONE cycle: accepted back-to-back, second result correct.
6. Reset mid-operation:
   - Stimulus: assert RST asynchronously during SHIFT of test 1.
   - Response: OUT=0, CARRY=0, BUSY=0, DONE=0 immediately, without a clock edge.
   - After release, a repeat of test 1 gives the same result.
